// File: rtl/bp_cfg_param_table_if.sv
// Host-side bundle for the config table: write/select handshakes,
// lock level and the active configuration outputs.
interface bp_cfg_param_table_if #(
   parameter int cfgs_p        = 16,
   parameter int fields_p      = 48,
   parameter int field_width_p = 16
);
   localparam int lg_cfgs   = $clog2(cfgs_p);
   localparam int lg_fields = $clog2(fields_p);

   logic                              w_v_i;
   logic                              w_ready_o;
   logic [lg_cfgs-1:0]                w_cfg_i;
   logic [lg_fields-1:0]              w_field_i;
   logic [field_width_p-1:0]          w_data_i;
   logic                              w_commit_i;
   logic                              w_err_o;
   logic                              sel_v_i;
   logic                              sel_ready_o;
   logic [lg_cfgs-1:0]                sel_cfg_i;
   logic                              sel_err_o;
   logic                              lock_i;
   logic [fields_p*field_width_p-1:0] active_o;
   logic                              active_v_o;
   logic [lg_cfgs-1:0]                active_cfg_o;

   modport master (
      output w_v_i, w_cfg_i, w_field_i, w_data_i, w_commit_i,
      output sel_v_i, sel_cfg_i, lock_i,
      input  w_ready_o, w_err_o, sel_ready_o, sel_err_o,
      input  active_o, active_v_o, active_cfg_o
   );

   modport slave (
      input  w_v_i, w_cfg_i, w_field_i, w_data_i, w_commit_i,
      input  sel_v_i, sel_cfg_i, lock_i,
      output w_ready_o, w_err_o, sel_ready_o, sel_err_o,
      output active_o, active_v_o, active_cfg_o
   );
endinterface

// File: rtl/bp_cfg_param_table.sv
// Programmable processor-config table; a selected entry is copied
// one field per cycle into the active shadow register.
module bp_cfg_param_table #(
   parameter int cfgs_p        = 16,
   parameter int fields_p      = 48,
   parameter int field_width_p = 16
) (
   input logic                 clk_i,
   input logic                 reset_n_i,
   bp_cfg_param_table_if.slave bus
);
   localparam int lg_cfgs   = $clog2(cfgs_p);
   localparam int lg_fields = $clog2(fields_p);

   localparam logic [lg_cfgs:0]     cfgs_lim   = (lg_cfgs+1)'(cfgs_p);
   localparam logic [lg_fields:0]   fields_lim = (lg_fields+1)'(fields_p);
   localparam logic [lg_fields-1:0] last_field = lg_fields'(fields_p - 1);

   typedef enum logic {e_idle, e_copy} state_e;

   state_e state_r, state_n;

   logic [field_width_p-1:0] mem_r [cfgs_p][fields_p];
   logic [cfgs_p-1:0]        valid_r, valid_n;
   logic [lg_fields-1:0]     cnt_r;
   logic [1:0]               rst_sync_r;
   logic                     rst_n;

   logic w_acc, w_cfg_bad, w_field_bad, w_lock_hit, w_rej, w_do;
   logic sel_acc, sel_cfg_bad, sel_ok, sel_go;

   // Assert asynchronously, release on the clock.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) rst_sync_r <= '0;
      else            rst_sync_r <= {rst_sync_r[0], 1'b1};
   end

   assign rst_n = rst_sync_r[1];

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) state_r <= e_idle;
      else        state_r <= state_n;
   end

   always_comb begin
      state_n = state_r;
      unique case (state_r)
         e_idle:  if (sel_go) state_n = e_copy;
         e_copy:  if (cnt_r == last_field) state_n = e_idle;
         default: state_n = e_idle;
      endcase
   end

   always_comb begin
      bus.w_ready_o   = 1'b0;
      bus.sel_ready_o = 1'b0;
      unique case (state_r)
         e_idle: begin
            bus.w_ready_o   = 1'b1;
            bus.sel_ready_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_acc   = bus.w_v_i & bus.w_ready_o;
   assign sel_acc = bus.sel_v_i & bus.sel_ready_o;

   assign w_cfg_bad   = (bus.w_cfg_i == '0)
                      | ({1'b0, bus.w_cfg_i} >= cfgs_lim);
   assign w_field_bad = {1'b0, bus.w_field_i} >= fields_lim;
   assign w_lock_hit  = bus.lock_i & bus.active_v_o
                      & (bus.w_cfg_i == bus.active_cfg_o);
   assign w_rej       = w_cfg_bad | w_field_bad | w_lock_hit;
   assign w_do        = w_acc & ~w_rej;

   // A same-cycle select must see the valid bit after this write.
   always_comb begin
      valid_n = valid_r;
      if (w_do) valid_n[bus.w_cfg_i] = bus.w_commit_i;
   end

   assign sel_cfg_bad = (bus.sel_cfg_i == '0)
                      | ({1'b0, bus.sel_cfg_i} >= cfgs_lim);
   assign sel_ok      = ~sel_cfg_bad & valid_n[bus.sel_cfg_i];
   assign sel_go      = sel_acc & sel_ok;

   always_ff @(posedge clk_i) begin
      if (w_do) mem_r[bus.w_cfg_i][bus.w_field_i] <= bus.w_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         valid_r          <= '0;
         cnt_r            <= '0;
         bus.active_o     <= '0;
         bus.active_v_o   <= 1'b0;
         bus.active_cfg_o <= '0;
         bus.w_err_o      <= 1'b0;
         bus.sel_err_o    <= 1'b0;
      end else begin
         valid_r       <= valid_n;
         bus.w_err_o   <= w_acc & w_rej;
         bus.sel_err_o <= sel_acc & ~sel_ok;
         if (sel_go) begin
            cnt_r            <= '0;
            bus.active_v_o   <= 1'b0;
            bus.active_cfg_o <= bus.sel_cfg_i;
         end else if (state_r == e_copy) begin
            bus.active_o[cnt_r*field_width_p +: field_width_p]
               <= mem_r[bus.active_cfg_o][cnt_r];
            if (cnt_r == last_field) begin
               cnt_r          <= '0;
               bus.active_v_o <= 1'b1;
            end else begin
               cnt_r <= cnt_r + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_bp_cfg_param_table.sv
// Randomised and directed bench for bp_cfg_param_table against
// an array-based model of the table and active register.
module tb_bp_cfg_param_table;
   localparam int NC = 16;
   localparam int NF = 48;
   localparam int FW = 16;
   localparam int AW = NC == 16 ? 768 : 768;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   bp_cfg_param_table_if #(.cfgs_p(NC), .fields_p(NF), .field_width_p(FW)) b();

   bp_cfg_param_table #(.cfgs_p(NC), .fields_p(NF), .field_width_p(FW)) dut (
      .clk_i(clk),
      .reset_n_i(reset_n),
      .bus(b.slave)
   );

   logic [FW-1:0] m_mem [NC][64];
   bit            m_valid [NC];
   logic [FW-1:0] m_act [NF];
   bit            m_act_v;
   int            m_act_cfg;
   bit            m_lock;

   function automatic void m_reset();
      for (int i = 0; i < NC; i++) m_valid[i] = 0;
      for (int k = 0; k < NF; k++) m_act[k] = '0;
      m_act_v = 0;
      m_act_cfg = 0;
   endfunction

   function automatic bit m_write(int cfg, int fld, logic [FW-1:0] d, bit c);
      if (cfg == 0 || cfg >= NC || fld >= NF) return 1;
      if (m_lock && m_act_v && cfg == m_act_cfg) return 1;
      m_mem[cfg][fld] = d;
      m_valid[cfg] = c;
      return 0;
   endfunction

   function automatic bit m_select(int cfg);
      if (cfg == 0 || cfg >= NC || !m_valid[cfg]) return 1;
      for (int k = 0; k < NF; k++) m_act[k] = m_mem[cfg][k];
      m_act_v = 1;
      m_act_cfg = cfg;
      return 0;
   endfunction

   function automatic logic [AW-1:0] m_active();
      logic [AW-1:0] v;
      v = '0;
      for (int k = 0; k < NF; k++) v[k*FW +: FW] = m_act[k];
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input int cfg, input int fld, input logic [FW-1:0] d,
                           input bit c, output logic err);
      int n;
      n = 0;
      b.w_v_i = 1'b1;
      b.w_cfg_i = cfg[3:0];
      b.w_field_i = fld[5:0];
      b.w_data_i = d;
      b.w_commit_i = c;
      while (!b.w_ready_o && n < 200) begin
         step();
         n++;
      end
      step();
      b.w_v_i = 1'b0;
      b.w_commit_i = 1'b0;
      err = (n >= 200) ? 1'bx : b.w_err_o;
   endtask

   task automatic do_select(input int cfg, output logic err, output int lat);
      int n;
      n = 0;
      lat = 0;
      b.sel_v_i = 1'b1;
      b.sel_cfg_i = cfg[3:0];
      while (!b.sel_ready_o && n < 200) begin
         step();
         n++;
      end
      step();
      b.sel_v_i = 1'b0;
      err = (n >= 200) ? 1'bx : b.sel_err_o;
      if (err === 1'b0) begin
         while (!b.active_v_o && lat < 200) begin
            step();
            lat++;
         end
      end
   endtask

   task automatic test_reset();
      total++;
      if (b.active_v_o !== 1'b0) begin
         bad++; $display("FAIL reset_active_v: got %b want 0", b.active_v_o);
      end
      total++;
      if (b.active_o !== '0) begin
         bad++; $display("FAIL reset_active: got %h want 0", b.active_o);
      end
      total++;
      if (b.active_cfg_o !== 4'd0) begin
         bad++; $display("FAIL reset_cfg: got %0d want 0", b.active_cfg_o);
      end
      total++;
      if ({b.w_err_o, b.sel_err_o} !== 2'b00) begin
         bad++; $display("FAIL reset_err: got %b want 00", {b.w_err_o, b.sel_err_o});
      end
      total++;
      if ({b.w_ready_o, b.sel_ready_o} !== 2'b11) begin
         bad++; $display("FAIL reset_ready: got %b want 11", {b.w_ready_o, b.sel_ready_o});
      end
   endtask

   task automatic test_write_select();
      logic e, ee;
      int   lat;
      int   errs;
      errs = 0;
      for (int k = 0; k < NF; k++) begin
         ee = m_write(3, k, 16'h0300 + 16'(k), k == NF - 1);
         do_write(3, k, 16'h0300 + 16'(k), k == NF - 1, e);
         if (e !== ee) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++; $display("FAIL fill3_err: got %0d want 0 errors", errs);
      end
      ee = m_select(3);
      do_select(3, e, lat);
      total++;
      if (e !== ee) begin
         bad++; $display("FAIL sel3_err: got %b want %b", e, ee);
      end
      total++;
      if (lat != NF) begin
         bad++; $display("FAIL sel3_lat: got %0d want %0d", lat, NF);
      end
      total++;
      if (b.active_o !== m_active()) begin
         bad++; $display("FAIL sel3_data: got %h want %h", b.active_o, m_active());
      end
      total++;
      if (b.active_cfg_o !== 4'd3) begin
         bad++; $display("FAIL sel3_cfg: got %0d want 3", b.active_cfg_o);
      end
   endtask

   task automatic test_sel_err();
      logic e;
      int   lat;
      int   cfgs [2];
      cfgs[0] = 0;
      cfgs[1] = 5;
      foreach (cfgs[i]) begin
         void'(m_select(cfgs[i]));
         do_select(cfgs[i], e, lat);
         total++;
         if (e !== 1'b1) begin
            bad++; $display("FAIL selerr_%0d: got %b want 1", cfgs[i], e);
         end
         step();
         total++;
         if (b.sel_err_o !== 1'b0) begin
            bad++; $display("FAIL selerr_pulse_%0d: got %b want 0", cfgs[i], b.sel_err_o);
         end
         total++;
         if (b.active_v_o !== 1'b1 || b.active_o !== m_active()) begin
            bad++; $display("FAIL selerr_keep_%0d: got v=%b %h want v=1 %h",
                            cfgs[i], b.active_v_o, b.active_o, m_active());
         end
      end
   endtask

   task automatic test_lock();
      logic e, ee;
      int   lat;
      m_lock = 1;
      b.lock_i = 1'b1;
      ee = m_write(3, 2, 16'hBEEF, 0);
      do_write(3, 2, 16'hBEEF, 0, e);
      total++;
      if (e !== ee || e !== 1'b1) begin
         bad++; $display("FAIL lock_werr: got %b want 1", e);
      end
      void'(m_select(3));
      do_select(3, e, lat);
      total++;
      if (e !== 1'b0 || b.active_o[2*FW +: FW] !== 16'h0302) begin
         bad++; $display("FAIL lock_keep: got e=%b f2=%h want e=0 f2=0302",
                         e, b.active_o[2*FW +: FW]);
      end
      m_lock = 0;
      b.lock_i = 1'b0;
      ee = m_write(3, 2, 16'hBEEF, 1);
      do_write(3, 2, 16'hBEEF, 1, e);
      total++;
      if (e !== ee) begin
         bad++; $display("FAIL unlock_werr: got %b want %b", e, ee);
      end
      total++;
      if (b.active_o !== m_active()) begin
         bad++; $display("FAIL unlock_hold: got %h want %h", b.active_o, m_active());
      end
      ee = m_select(3);
      do_select(3, e, lat);
      total++;
      if (e !== ee || b.active_o[2*FW +: FW] !== 16'hBEEF) begin
         bad++; $display("FAIL unlock_new: got e=%b f2=%h want e=%b f2=beef",
                         e, b.active_o[2*FW +: FW], ee);
      end
   endtask

   task automatic test_commit();
      logic e, ee;
      int   lat;
      for (int k = 0; k < NF; k++) begin
         void'(m_write(4, k, 16'h0400 + 16'(k), k == NF - 1));
         do_write(4, k, 16'h0400 + 16'(k), k == NF - 1, e);
      end
      ee = m_select(4);
      do_select(4, e, lat);
      total++;
      if (e !== ee || e !== 1'b0) begin
         bad++; $display("FAIL commit_first: got %b want 0", e);
      end
      void'(m_write(4, 0, 16'h4444, 0));
      do_write(4, 0, 16'h4444, 0, e);
      ee = m_select(4);
      do_select(4, e, lat);
      total++;
      if (e !== ee || e !== 1'b1) begin
         bad++; $display("FAIL uncommit_sel: got %b want 1", e);
      end
      void'(m_write(4, 0, 16'h4445, 1));
      do_write(4, 0, 16'h4445, 1, e);
      ee = m_select(4);
      do_select(4, e, lat);
      total++;
      if (e !== ee || b.active_o !== m_active()) begin
         bad++; $display("FAIL recommit_sel: got e=%b %h want e=%b %h",
                         e, b.active_o, ee, m_active());
      end
   endtask

   task automatic test_busy();
      int            n, lat;
      bit            leak;
      logic          ee_w, ee_s;
      logic [FW-1:0] d;
      d = FW'($urandom);
      leak = 0;
      void'(m_select(3));
      b.sel_v_i = 1'b1;
      b.sel_cfg_i = 4'd3;
      step();
      b.sel_cfg_i = 4'd4;
      b.w_v_i = 1'b1;
      b.w_cfg_i = 4'd4;
      b.w_field_i = 6'd5;
      b.w_data_i = d;
      b.w_commit_i = 1'b1;
      n = 0;
      while (!b.w_ready_o && n < 200) begin
         if (b.sel_ready_o !== 1'b0) leak = 1;
         step();
         n++;
      end
      total++;
      if (n != NF || leak) begin
         bad++; $display("FAIL busy_ready: got %0d cycles leak=%b want %0d leak=0",
                         n, leak, NF);
      end
      total++;
      if (b.active_v_o !== 1'b1 || b.active_o !== m_active()) begin
         bad++; $display("FAIL busy_copy: got v=%b %h want v=1 %h",
                         b.active_v_o, b.active_o, m_active());
      end
      ee_w = m_write(4, 5, d, 1);
      ee_s = m_select(4);
      step();
      b.w_v_i = 1'b0;
      b.sel_v_i = 1'b0;
      b.w_commit_i = 1'b0;
      total++;
      if (b.w_err_o !== ee_w || b.sel_err_o !== ee_s) begin
         bad++; $display("FAIL busy_accept: got w=%b s=%b want w=%b s=%b",
                         b.w_err_o, b.sel_err_o, ee_w, ee_s);
      end
      lat = 0;
      while (!b.active_v_o && lat < 200) begin
         step();
         lat++;
      end
      total++;
      if (lat != NF || b.active_o !== m_active() || b.active_cfg_o !== 4'd4) begin
         bad++; $display("FAIL busy_newdata: got lat=%0d cfg=%0d %h want lat=%0d cfg=4 %h",
                         lat, b.active_cfg_o, b.active_o, NF, m_active());
      end
   endtask

   task automatic test_random();
      logic e;
      for (int c = 1; c < NC; c++) begin
         for (int k = 0; k < NF; k++) begin
            logic [FW-1:0] d;
            d = FW'($urandom);
            void'(m_write(c, k, d, k == NF - 1));
            do_write(c, k, d, k == NF - 1, e);
         end
      end
      for (int i = 0; i < 80; i++) begin
         int            cfg, fld, lat;
         logic [FW-1:0] d;
         bit            cm;
         logic          ee;
         m_lock = ($urandom_range(0, 3) == 0);
         b.lock_i = m_lock;
         cfg = ($urandom_range(0, 3) == 0) ? m_act_cfg : int'($urandom_range(0, NC - 1));
         if ($urandom_range(0, 2) != 0) begin
            fld = $urandom_range(0, 55);
            d = FW'($urandom);
            cm = ($urandom_range(0, 3) != 0);
            ee = m_write(cfg, fld, d, cm);
            do_write(cfg, fld, d, cm, e);
            total++;
            if (e !== ee) begin
               bad++; $display("FAIL rand_werr[%0d] cfg=%0d f=%0d: got %b want %b",
                               i, cfg, fld, e, ee);
            end
         end else begin
            ee = m_select(cfg);
            do_select(cfg, e, lat);
            total++;
            if (e !== ee || (!ee && lat != NF)) begin
               bad++; $display("FAIL rand_sel[%0d] cfg=%0d: got e=%b lat=%0d want e=%b lat=%0d",
                               i, cfg, e, lat, ee, NF);
            end
         end
         total++;
         if (b.active_o !== m_active() || b.active_v_o !== m_act_v
             || b.active_cfg_o !== 4'(m_act_cfg)) begin
            bad++; $display("FAIL rand_active[%0d]: got v=%b c=%0d %h want v=%b c=%0d %h",
                            i, b.active_v_o, b.active_cfg_o, b.active_o,
                            m_act_v, m_act_cfg, m_active());
         end
      end
      m_lock = 0;
      b.lock_i = 1'b0;
   endtask

   task automatic test_reset_mid_copy();
      logic e;
      int   lat;
      void'(m_write(3, 0, 16'h3333, 1));
      do_write(3, 0, 16'h3333, 1, e);
      b.sel_v_i = 1'b1;
      b.sel_cfg_i = 4'd3;
      step();
      b.sel_v_i = 1'b0;
      repeat (20) step();
      total++;
      if (b.active_v_o !== 1'b0) begin
         bad++; $display("FAIL midcopy_v: got %b want 0", b.active_v_o);
      end
      #2 reset_n = 1'b0;
      #1;
      m_reset();
      total++;
      if (b.active_v_o !== 1'b0 || b.active_o !== '0 || b.active_cfg_o !== 4'd0) begin
         bad++; $display("FAIL async_reset: got v=%b c=%0d %h want all 0",
                         b.active_v_o, b.active_cfg_o, b.active_o);
      end
      repeat (2) step();
      reset_n = 1'b1;
      repeat (4) step();
      do_select(3, e, lat);
      total++;
      if (e !== 1'b1) begin
         bad++; $display("FAIL post_reset_sel: got %b want 1", e);
      end
   endtask

   initial begin
      b.w_v_i = 1'b0;
      b.w_cfg_i = '0;
      b.w_field_i = '0;
      b.w_data_i = '0;
      b.w_commit_i = 1'b0;
      b.sel_v_i = 1'b0;
      b.sel_cfg_i = '0;
      b.lock_i = 1'b0;
      m_lock = 0;
      m_reset();
      repeat (3) step();
      reset_n = 1'b1;
      repeat (4) step();
      test_reset();
      test_write_select();
      test_sel_err();
      test_lock();
      test_commit();
      test_busy();
      test_random();
      test_reset_mid_copy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bp_cfg_param_table.md
Name: bp_cfg_param_table

Overview:
- Runtime-programmable processor-configuration table.
- Holds `cfgs_p` configuration entries of `fields_p` fields each. Entries are written over a host handshake.
- On a select command, the chosen entry is copied field-by-field into an active shadow register that drives the tile's configuration outputs.
- Successor to compile-time fixed config lists: entry count, field count and width are parameters; entries are programmable, validity-tracked and lockable.

Parameters:
- cfgs_p, 16, number of table entries; entry 0 is the reserved invalid config and is never writable.
- fields_p, 48, fields per entry.
- field_width_p, 16, bits per field.
- Derived: lg_cfgs = clog2(cfgs_p); lg_fields = clog2(fields_p).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; asynchronous, active-low.
- w_v_i  in  1  write request valid.
- w_ready_o  out  1  write accept; a write completes when w_v_i & w_ready_o.
- w_cfg_i  in  lg_cfgs  target entry.
- w_field_i  in  lg_fields  target field.
- w_data_i  in  field_width_p  write data.
- w_commit_i  in  1  sampled with an accepted write; marks the entry valid after this write.
- w_err_o  out  1  one-cycle pulse, the cycle after an accepted write that was rejected.
- sel_v_i  in  1  select request.
- sel_ready_o  out  1  select accept.
- sel_cfg_i  in  lg_cfgs  entry to activate.
- sel_err_o  out  1  one-cycle pulse: select rejected.
- lock_i  in  1  level; while high, writes to the active entry are rejected.
- active_o  out  fields_p*field_width_p  active configuration; field k occupies bits [k*field_width_p +: field_width_p].
- active_v_o  out  1  active_o is complete and consistent.
- active_cfg_o  out  lg_cfgs  index currently active.

Behaviour:
- Reset (async assert, sync deassert inside):
  - all valid bits 0; active_o = 0; active_v_o = 0; active_cfg_o = 0.
  - w_err_o = 0; sel_err_o = 0; FSM = e_idle; field counter = 0.
  - Table storage is not reset.
- FSM states: e_idle, e_copy.
- e_idle:
  - w_ready_o = 1 and sel_ready_o = 1.
  - Accepted select of an entry with valid = 1 and index != 0:
    - counter <= 0; active_v_o <= 0; active_cfg_o <= sel_cfg_i; next state e_copy.
  - Accepted select of entry 0, an invalid entry, or an index >= cfgs_p: sel_err_o pulses next cycle; active state is unchanged.
- e_copy:
  - w_ready_o = 0 and sel_ready_o = 0.
  - Each cycle, field[counter] of the entry is copied into active_o and the counter increments.
  - After field fields_p-1 is copied: active_v_o <= 1; next state e_idle.
  - Copy latency is exactly fields_p cycles from the accept edge to active_v_o high.
- Writes:
  - Accepted writes store data in the cycle after the accept edge.
  - A write is rejected (no storage update, w_err_o pulse) if the target is:
    - entry 0, an index >= cfgs_p, or a field >= fields_p; or
    - the active entry while lock_i = 1 and active_v_o = 1.
  - An accepted, non-rejected write to a valid entry clears that entry's valid bit unless w_commit_i = 1.
  - A write with w_commit_i = 1 sets the valid bit.
  - A non-rejected write to the active entry while unlocked does not alter active_o until that entry is re-selected.
- Simultaneous w_v_i and sel_v_i in e_idle: both are accepted; the write is processed first.
  - A select of the entry being written sees the valid bit as updated by that write.
  - If the copy proceeds, it reads the new data.
- Reset mid-copy: active_v_o drops immediately and all state returns to reset values.
- active_o is held stable (no partial updates visible) whenever active_v_o = 1.

Test Plan:
1. Reset, then write cfg 3 fields 0..47 with data 16'h0300+k, commit on field 47, select cfg 3 → active_v_o high exactly 48 cycles after the accept edge; field k of active_o = 16'h0300+k; active_cfg_o = 3.
2. Select cfg 0, then select cfg 5 (never written) → sel_err_o pulses once per select; active_v_o and active_o unchanged.
3. With cfg 3 active and lock_i = 1, write cfg 3 field 2 = 16'hBEEF → w_err_o pulses; re-select cfg 3 → field 2 still 16'h0302. Repeat with lock_i = 0 → no error; re-select → field 2 = 16'hBEEF.
4. Write cfg 4 field 0 without commit after cfg 4 was valid → select cfg 4 is rejected with sel_err_o; a committing write restores validity and the select then succeeds.
5. Issue w_v_i and sel_v_i during e_copy → w_ready_o and sel_ready_o stay 0 for all 48 copy cycles; the requests are accepted on the first cycle back in e_idle.
6. Deassert reset_n_i at copy cycle 20 → active_v_o = 0, active_o = 0 and valid bits = 0 asynchronously; after release, selecting cfg 3 errors.
